// File: rtl/gearbox_8b10b_tx_pkg.sv
// Shared constants, mode encoding and rate decode for the 8b10b transmit gearbox.
package gearbox_8b10b_tx_pkg;

  localparam int unsigned SYM_W = 10;

  // Alternating pattern: DC balanced and keeps the receiver CDR toggling during idle.
  localparam logic [SYM_W-1:0] FILL_SYM = 10'b1010101010;

  typedef enum logic [1:0] {
    GB_X1   = 2'd0,
    GB_X2   = 2'd1,
    GB_X4   = 2'd2,
    GB_RSVD = 2'd3
  } gb_mode_e;

  // Bits per cycle for a mode; the reserved code falls back to the slowest rate.
  function automatic logic [2:0] gb_bits(gb_mode_e mode);
    logic [2:0] bits;
    case (mode)
      GB_X2:   bits = 3'd2;
      GB_X4:   bits = 3'd4;
      default: bits = 3'd1;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/gearbox_8b10b_tx.sv
// Transmit gearbox: serialises SYMS-symbol 8b10b words at 1, 2 or 4 bits per cycle.
// The rate is latched per word at the word boundary; an idle FILL word is inserted
// whenever no word is offered at a boundary so the line never starves.
// Optional build macro BILIB_GEARBOX_UNDERRUN_CNT_EN adds a saturating underrun
// counter (underrun_cnt_o) with a synchronous clear (clr_cnt_i).
module gearbox_8b10b_tx
  import gearbox_8b10b_tx_pkg::*;
#(
  parameter int unsigned SYMS = 2,
  parameter int unsigned OUT_W = 4,
  localparam int unsigned WORD_W = SYM_W * SYMS,
  parameter logic [WORD_W-1:0] FILL = {SYMS{FILL_SYM}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        mode_i,
  output logic [OUT_W-1:0]  serial_o,
  output logic              underrun_o
`ifdef BILIB_GEARBOX_UNDERRUN_CNT_EN
  ,
  input  logic              clr_cnt_i,
  output logic [15:0]       underrun_cnt_o
`endif
);

  localparam int unsigned REM_W = $clog2(WORD_W + 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(WORD_W);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [2:0]        k_q, k_d;
  logic              underrun_q, underrun_d;
  logic [REM_W-1:0]  k_ext;
  logic              boundary;

  assign k_ext    = REM_W'(k_q);
  // Last slice of the current word goes out this cycle; the next word loads on this edge.
  assign boundary = (rem_q == k_ext);

  assign ready_o    = boundary;
  assign underrun_o = underrun_q;

  // Next-state: shift by the latched rate mid-word, reload (data or FILL) at the boundary.
  always_comb begin
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    k_d        = k_q;
    underrun_d = 1'b0;
    if (boundary) begin
      shreg_d    = valid_i ? word_i : FILL;
      underrun_d = ~valid_i;
      rem_d      = REM_FULL;
      k_d        = gb_bits(gb_mode_e'(mode_i));
    end else begin
      rem_d = rem_q - k_ext;
      case (k_q)
        3'd2:    shreg_d = {shreg_q[WORD_W-3:0], 2'b00};
        3'd4:    shreg_d = {shreg_q[WORD_W-5:0], 4'b0000};
        default: shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
      endcase
    end
  end

  // Output slice: top k bits of the shifter, MSB-aligned, unused lanes held at zero.
  always_comb begin
    serial_o = '0;
    case (k_q)
      3'd2:    serial_o[OUT_W-1 -: 2] = shreg_q[WORD_W-1 -: 2];
      3'd4:    serial_o[OUT_W-1 -: 4] = shreg_q[WORD_W-1 -: 4];
      default: serial_o[OUT_W-1]      = shreg_q[WORD_W-1];
    endcase
  end

  // Datapath state; reset restarts with a full FILL word at the slowest rate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q    <= FILL;
      rem_q      <= REM_FULL;
      k_q        <= 3'd1;
      underrun_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      rem_q      <= rem_d;
      k_q        <= k_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef BILIB_GEARBOX_UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of underrun pulses; clear beats a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (underrun_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign underrun_cnt_o = cnt_q;
`endif

  // WORD_W is a multiple of every rate, so rem must land exactly on k_q and never wrap.
  a_rem_no_wrap: assert property (@(posedge clk_i) disable iff (rst_i)
    (rem_q >= k_ext) && (rem_q != '0));

  // The reserved rate code is only tolerated, never expected from the encoder.
  a_mode_rsvd: assert property (@(posedge clk_i) disable iff (rst_i)
    boundary |-> (gb_mode_e'(mode_i) != GB_RSVD));

endmodule

// File: tb/tb_gearbox_8b10b_tx.sv
module tb_gearbox_8b10b_tx;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] word = '0;
  logic         valid = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         ready_o;
  logic [3:0]   serial_o;
  logic         underrun_o;
`ifdef BILIB_GEARBOX_UNDERRUN_CNT_EN
  logic         clr = 1'b0;
  logic [15:0]  cnt_o;
  int           m_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gearbox_8b10b_tx dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .word_i     (word),
    .valid_i    (valid),
    .ready_o    (ready_o),
    .mode_i     (mode),
    .serial_o   (serial_o),
    .underrun_o (underrun_o)
`ifdef BILIB_GEARBOX_UNDERRUN_CNT_EN
    ,
    .clr_cnt_i      (clr),
    .underrun_cnt_o (cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the word in flight is a queue of bits, earliest first.
  logic [W-1:0] fill_v = 20'hAAAAA;
  bit           m_q[$];
  int           m_k;
  bit           m_und;

  function automatic void m_load(input logic [W-1:0] src);
    for (int i = W - 1; i >= 0; i--) m_q.push_back(src[i]);
  endfunction

  function automatic void m_reset();
    m_q   = {};
    m_load(fill_v);
    m_k   = 1;
    m_und = 1'b0;
`ifdef BILIB_GEARBOX_UNDERRUN_CNT_EN
    m_cnt = 0;
`endif
  endfunction

  function automatic logic [3:0] m_serial();
    logic [3:0] s = '0;
    for (int i = 0; i < m_k; i++) s[3-i] = m_q[i];
    return s;
  endfunction

  function automatic logic m_ready();
    return m_q.size() == m_k;
  endfunction

  function automatic void m_step(input logic v, input logic [W-1:0] w, input logic [1:0] m);
`ifdef BILIB_GEARBOX_UNDERRUN_CNT_EN
    if (clr) m_cnt = 0;
    else if (m_und && m_cnt < 65535) m_cnt++;
`endif
    for (int i = 0; i < m_k; i++) void'(m_q.pop_front());
    if (m_q.size() == 0) begin
      m_load(v ? w : fill_v);
      m_k   = (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
      m_und = ~v;
    end else begin
      m_und = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: compare against the model, then apply inputs across the edge.
  task automatic cycle(input logic v, input logic [W-1:0] w, input logic [1:0] m);
    valid = v;
    word  = w;
    mode  = m;
    check("serial", 32'(serial_o), 32'(m_serial()));
    check("ready", 32'(ready_o), 32'(m_ready()));
    check("underrun", 32'(underrun_o), 32'(m_und));
`ifdef BILIB_GEARBOX_UNDERRUN_CNT_EN
    check("underrun_cnt", 32'(cnt_o), 32'(m_cnt));
`endif
    @(posedge clk);
    m_step(v, w, m);
    #1;
  endtask

  // Runs one word; n is the in-word cycle index at which ready_o was seen (-1 on timeout).
  task automatic count_word(input logic v, input logic [W-1:0] w, input logic [1:0] m0,
                            input logic [1:0] m1, input int sw, output int n);
    logic rdy;
    n = -1;
    for (int i = 0; i < 64; i++) begin
      rdy = ready_o;
      cycle(v, w, (i >= sw) ? m1 : m0);
      if (rdy) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic         valid;
    logic [W-1:0] word;
    logic [1:0]   mode;
    logic [3:0]   ser;
    logic         rdy;
    logic         und;
  } vec_t;

  vec_t tbl[61];
  int   n;

  initial begin
    // Directed vectors from reset: two FILL words at X1 (second via underrun),
    // ABCDE twice at X4, 80001 at X2, then an underrun into FILL.
    for (int c = 0; c < 61; c++) begin
      tbl[c] = '{valid: 1'b0, word: 20'hABCDE, mode: 2'd0, ser: 4'h0, rdy: 1'b0, und: 1'b0};
      if (c < 40) begin
        tbl[c].ser = ((c % 2) == 0) ? 4'b1000 : 4'b0000;
        tbl[c].rdy = (c == 19) || (c == 39);
        tbl[c].und = (c == 20);
        if (c == 39) begin
          tbl[c].valid = 1'b1;
          tbl[c].mode  = 2'd2;
        end
      end else if (c < 50) begin
        tbl[c].ser   = 4'hA + 4'((c - 40) % 5);
        tbl[c].rdy   = ((c - 40) % 5) == 4;
        tbl[c].valid = 1'b1;
        tbl[c].mode  = 2'd2;
        if (c == 49) begin
          tbl[c].word = 20'h80001;
          tbl[c].mode = 2'd1;
        end
      end else if (c < 60) begin
        tbl[c].ser = (c == 50) ? 4'b1000 : (c == 59) ? 4'b0100 : 4'b0000;
        tbl[c].rdy = (c == 59);
      end else begin
        tbl[c].ser = 4'b1000;
        tbl[c].und = 1'b1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();

    for (int c = 0; c < 61; c++) begin
      check($sformatf("tbl_serial[%0d]", c), 32'(serial_o), 32'(tbl[c].ser));
      check($sformatf("tbl_ready[%0d]", c), 32'(ready_o), 32'(tbl[c].rdy));
      check($sformatf("tbl_underrun[%0d]", c), 32'(underrun_o), 32'(tbl[c].und));
      cycle(tbl[c].valid, tbl[c].word, tbl[c].mode);
    end

    // Mode change X1->X4 three cycles into a word: old word finishes at X1.
    count_word(1'b0, '0, 2'd0, 2'd0, 0, n);
    check("align_boundary", 32'(n >= 0), 32'd1);
    count_word(1'b1, 20'h5A5A5, 2'd0, 2'd2, 3, n);
    check("x1_word_len", 32'(n), 32'd19);
    count_word(1'b1, 20'h0F0F0, 2'd2, 2'd2, 0, n);
    check("x4_word_len", 32'(n), 32'd4);

    // Single dropped boundary: exactly one FILL word, one underrun pulse.
    count_word(1'b0, '0, 2'd2, 2'd2, 0, n);
    check("pre_drop_len", 32'(n), 32'd4);
    check("drop_pulse", 32'(underrun_o), 32'd1);
    check("drop_fill_top", 32'(serial_o), 32'hA);
    count_word(1'b1, 20'h13579, 2'd2, 2'd2, 0, n);
    check("fill_word_len", 32'(n), 32'd4);
    check("drop_pulse_end", 32'(underrun_o), 32'd0);
    check("post_drop_data", 32'(serial_o), 32'h1);

    // Asynchronous reset mid-word at X4.
    cycle(1'b1, 20'h13579, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_serial", 32'(serial_o), 32'b1000);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_underrun", 32'(underrun_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    count_word(1'b1, 20'h2468A, 2'd2, 2'd2, 0, n);
    check("rst_first_accept", 32'(n), 32'd19);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
`ifdef BILIB_GEARBOX_UNDERRUN_CNT_EN
      clr = ($urandom_range(0, 15) == 0);
`endif
      cycle($urandom_range(0, 3) != 0, W'($urandom), 2'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
